// File: rtl/rib_arbiter_2m.sv
// Two-master to one-slave RIB arbiter: round-robin request arbitration with
// in-order response routing through a small ID FIFO of accepted transactions.
module rib_arbiter_2m #(
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [63:0] i_ribm_addr,
  input  logic [1:0]  i_ribm_wrcs,
  input  logic [7:0]  i_ribm_mask,
  input  logic [63:0] i_ribm_wdata,
  input  logic [1:0]  i_ribm_req,
  output logic [1:0]  o_ribm_gnt,
  output logic [63:0] o_ribm_rdata,
  output logic [1:0]  o_ribm_rsp,
  input  logic [1:0]  i_ribm_rdy,
  output logic [31:0] o_ribs_addr,
  output logic        o_ribs_wrcs,
  output logic [3:0]  o_ribs_mask,
  output logic [31:0] o_ribs_wdata,
  output logic        o_ribs_req,
  input  logic        i_ribs_gnt,
  input  logic [31:0] i_ribs_rdata,
  input  logic        i_ribs_rsp,
  output logic        o_ribs_rdy,
  output logic        o_busy,
  output logic        o_err_unexp
);

  localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(OUTSTANDING) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_e;

  logic [CNT_W-1:0]       count;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [OUTSTANDING-1:0] id_fifo;
  master_e                last_grant;
  master_e                sel;
  master_e                head;
  logic                   err_unexp_q;

  logic any_req;
  logic full;
  logic empty;
  logic accept;
  logic pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign any_req = |i_ribm_req;
  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);

  // Round-robin: on a tie the master that did not win last time is selected.
  always_comb begin
    unique case (i_ribm_req)
      2'b01:   sel = M0;
      2'b10:   sel = M1;
      2'b11:   sel = (last_grant == M0) ? M1 : M0;
      default: sel = last_grant;
    endcase
  end

  assign o_ribs_req = any_req & ~full;
  assign accept     = o_ribs_req & i_ribs_gnt;

  always_comb begin
    o_ribs_addr  = '0;
    o_ribs_wrcs  = 1'b0;
    o_ribs_mask  = '0;
    o_ribs_wdata = '0;
    if (any_req) begin
      if (sel == M1) begin
        o_ribs_addr  = i_ribm_addr[63:32];
        o_ribs_wrcs  = i_ribm_wrcs[1];
        o_ribs_mask  = i_ribm_mask[7:4];
        o_ribs_wdata = i_ribm_wdata[63:32];
      end else begin
        o_ribs_addr  = i_ribm_addr[31:0];
        o_ribs_wrcs  = i_ribm_wrcs[0];
        o_ribs_mask  = i_ribm_mask[3:0];
        o_ribs_wdata = i_ribm_wdata[31:0];
      end
    end
  end

  always_comb begin
    o_ribm_gnt      = '0;
    o_ribm_gnt[sel] = accept;
  end

  assign head = master_e'(id_fifo[rd_ptr]);

  always_comb begin
    o_ribm_rsp = '0;
    if (!empty) begin
      o_ribm_rsp[head] = i_ribs_rsp;
    end
  end

  assign o_ribs_rdy   = ~empty & i_ribm_rdy[head];
  assign pop          = i_ribs_rsp & o_ribs_rdy;
  assign o_ribm_rdata = {2{i_ribs_rdata}};
  assign o_busy       = ~empty;
  assign o_err_unexp  = err_unexp_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      id_fifo    <= '0;
      wr_ptr     <= '0;
      last_grant <= M1;
    end else if (accept) begin
      id_fifo[wr_ptr] <= sel;
      wr_ptr          <= ptr_inc(wr_ptr);
      last_grant      <= sel;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Accept is already gated by full, so push and pop together never overflow.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count <= '0;
    end else begin
      unique case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      err_unexp_q <= 1'b0;
    end else if (i_ribs_rsp && empty) begin
      err_unexp_q <= 1'b1;
    end
  end

endmodule
